mac_seq_controller: RTL

- Parametrised successor to the MAC-unit controller FSM in the capsule-network datapath.
- Accepts an opcode and a run-time length through a start/busy handshake, instead of fixed 8/16/1152 compare inputs.
- Owns its element counter and sequences the MAC datapath controls (out_mode, sel1, ld_reg, en_cnt) for square, scale, matrix-MAC and column-sum operations.
- Reports completion with a one-cycle done pulse and rejects illegal commands with err.

---
 rtl/mac_seq_if.sv | 27 ++
 rtl/mac_seq_controller.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mac_seq_if.sv
// Command/status bundle between a MAC sequencer and its requester.
interface mac_seq_if #(
   parameter int CNT_W  = 11,
   parameter int MODE_W = 2
);
   logic              start;
   logic [2:0]        op;
   logic [CNT_W-1:0]  len;
   logic              busy;
   logic              done;
   logic              err;
   logic [CNT_W-1:0]  cnt;
   logic [MODE_W-1:0] out_mode;
   logic              sel1;
   logic              ld_reg;
   logic              en_cnt;

   modport master (
      output start, op, len,
      input  busy, done, err, cnt, out_mode, sel1, ld_reg, en_cnt
   );

   modport slave (
      input  start, op, len,
      output busy, done, err, cnt, out_mode, sel1, ld_reg, en_cnt
   );
endinterface

// File: rtl/mac_seq_controller.sv
// MAC datapath sequencer: accepts an opcode/length command, walks the
// PRE/LOAD/RUN/DONE phases for that op and owns the element counter.
module mac_seq_controller #(
   parameter int CNT_W  = 11,
   parameter int MODE_W = 2
) (
   input  logic     clk,
   input  logic     rst,
   mac_seq_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_LOAD = 3'd2,
      S_RUN  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [2:0] OP_SQ  = 3'd0;
   localparam logic [2:0] OP_SC  = 3'd1;
   localparam logic [2:0] OP_MAT = 3'd2;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic              busy, done, sel1, ld_reg, en_cnt;
   logic [MODE_W-1:0] out_mode;

   // State, command latches, element counter and reject pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Next state: accept/reject in IDLE, per-op entry point, RUN ends on cnt==len-1.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.op[2] || (bus.len == '0)) begin
                  err_d = 1'b1;
               end else begin
                  op_d  = bus.op;
                  len_d = bus.len;
                  cnt_d = '0;
                  case (bus.op)
                     OP_SQ:   state_d = S_PRE;
                     OP_SC:   state_d = S_LOAD;
                     default: state_d = S_RUN;
                  endcase
               end
            end
         end
         S_PRE:  state_d = S_LOAD;
         S_LOAD: state_d = S_RUN;
         S_RUN: begin
            // len is never 0 here, so len-1 cannot wrap; cnt stays <= len-1.
            if (cnt_q == (len_q - CNT_W'(1))) state_d = S_DONE;
            else                              cnt_d   = cnt_q + CNT_W'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Moore decode of the datapath controls from state and latched op.
   always_comb begin
      busy     = (state_q != S_IDLE);
      done     = 1'b0;
      sel1     = 1'b0;
      ld_reg   = 1'b0;
      en_cnt   = 1'b0;
      out_mode = '0;
      case (state_q)
         S_PRE:  out_mode = MODE_W'(2);
         S_LOAD: begin
            ld_reg = 1'b1;
            sel1   = (op_q == OP_SQ);
         end
         S_RUN: begin
            en_cnt = 1'b1;
            if (op_q == OP_SQ || op_q == OP_SC) out_mode = MODE_W'(1);
            else if (op_q == OP_MAT)            out_mode = MODE_W'(0);
            else                                out_mode = MODE_W'(3);
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.err      = err_q;
   assign bus.cnt      = cnt_q;
   assign bus.out_mode = out_mode;
   assign bus.sel1     = sel1;
   assign bus.ld_reg   = ld_reg;
   assign bus.en_cnt   = en_cnt;

endmodule
